// File: rtl/counter_cmd_ctrl_if.sv
// counter_cmd_ctrl_if
// Bundles the board-side inputs and the counter-side strobes of the
// counter command front-end.
//   btn_load_i  raw load button (async, active-high)
//   btn_step_i  raw step button (async, active-high)
//   sw_auto_i   raw mode switch, 1 = auto count
//   sw_data_i   raw load value switches
//   ld_o        one-cycle load strobe
//   cnt_o       one-cycle count strobe
//   d_o         load value, held until next load
//   auto_o      current mode, 1 = auto
// Modports: master drives the raw inputs (board / bench side),
//           slave is the controller.
interface counter_cmd_ctrl_if #(
  parameter int W = 4
);
  logic         btn_load_i;
  logic         btn_step_i;
  logic         sw_auto_i;
  logic [W-1:0] sw_data_i;
  logic         ld_o;
  logic         cnt_o;
  logic [W-1:0] d_o;
  logic         auto_o;

  modport master (
    output btn_load_i, btn_step_i, sw_auto_i, sw_data_i,
    input  ld_o, cnt_o, d_o, auto_o
  );

  modport slave (
    input  btn_load_i, btn_step_i, sw_auto_i, sw_data_i,
    output ld_o, cnt_o, d_o, auto_o
  );
endinterface

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl
// Command front-end for the 4-bit loadable up-counter. Synchronises the
// buttons and switches, debounces the two buttons, turns presses into
// single-cycle load / count strobes and generates an auto-count tick.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    counter_cmd_ctrl_if.slave (raw inputs in, strobes out)
// Parameters:
//   W                load data width
//   DEBOUNCE_CYCLES  stable cycles needed to accept a button change (>= 2)
//   TICK_DIV         clk cycles per auto-count tick (>= 2)
// Optional feature macro: CNT_CTRL_STEP_REPEAT_EN
//   When defined, a step button held for 8*TICK_DIV cycles after its press
//   in manual mode repeats a count strobe every TICK_DIV cycles.
//
// state  | meaning
// MANUAL | counts only on step presses, prescaler held at 0
// AUTO   | counts on prescaler wrap, step presses ignored
module counter_cmd_ctrl #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int TICK_DIV        = 50000000
) (
  input logic          clk,
  input logic          rst_n,
  counter_cmd_ctrl_if.slave bus
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW  = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

  state_t         state;

  // bit 0 = load button, bit 1 = step button
  logic [1:0]     btn_meta;
  logic [1:0]     btn_sync;
  logic [1:0]     btn_db;
  logic [1:0]     btn_db_q;
  logic [DBW-1:0] db_cnt [2];

  logic           auto_meta;
  logic           auto_sync;
  logic [W-1:0]   data_meta;
  logic [W-1:0]   data_sync;

  logic [PW-1:0]  presc;
  logic           ld;
  logic           cnt;
  logic [W-1:0]   d;
  logic           auto_mode;

  logic           load_evt;
  logic           step_evt;
  logic           tick;
  logic           step_fire;

  assign load_evt = btn_db[0] & ~btn_db_q[0];
  assign step_evt = btn_db[1] & ~btn_db_q[1];
  assign tick     = (state == AUTO) && (presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_db    <= '0;
      btn_db_q  <= '0;
      auto_meta <= 1'b0;
      auto_sync <= 1'b0;
      data_meta <= '0;
      data_sync <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      btn_meta  <= {bus.btn_step_i, bus.btn_load_i};
      btn_sync  <= btn_meta;
      auto_meta <= bus.sw_auto_i;
      auto_sync <= auto_meta;
      data_meta <= bus.sw_data_i;
      data_sync <= data_meta;
      btn_db_q  <= btn_db;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_db[i] <= btn_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef CNT_CTRL_STEP_REPEAT_EN
  localparam int RW = $clog2(8 * TICK_DIV + 1);
  localparam logic [RW-1:0] RPT_HOLD   = RW'(8 * TICK_DIV);
  // after a repeat, restart TICK_DIV-1 cycles short of the hold mark
  localparam logic [RW-1:0] RPT_RELOAD = RW'(7 * TICK_DIV + 1);

  // non-zero means a press in manual mode armed the repeat
  logic [RW-1:0] rpt;
  logic          rpt_fire;

  assign rpt_fire  = (rpt == RPT_HOLD) && btn_db[1];
  assign step_fire = (state == MANUAL) && !auto_sync && (step_evt || rpt_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt <= '0;
    end else if (state != MANUAL || auto_sync || !btn_db[1]) begin
      rpt <= '0;
    end else if (step_evt) begin
      rpt <= RW'(1);
    end else if (rpt_fire) begin
      rpt <= RPT_RELOAD;
    end else if (rpt != '0) begin
      rpt <= rpt + 1'b1;
    end
  end
`else
  // a press landing on the switch-to-auto edge is discarded
  assign step_fire = (state == MANUAL) && !auto_sync && step_evt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      presc     <= '0;
      ld        <= 1'b0;
      cnt       <= 1'b0;
      d         <= '0;
      auto_mode <= 1'b0;
    end else begin
      ld  <= load_evt;
      // load wins; a coincident count is dropped
      cnt <= !load_evt && (tick || step_fire);
      if (load_evt) d <= data_sync;
      case (state)
        MANUAL: begin
          presc <= '0;
          if (auto_sync) begin
            state     <= AUTO;
            auto_mode <= 1'b1;
          end
        end
        AUTO: begin
          if (!auto_sync) begin
            state     <= MANUAL;
            auto_mode <= 1'b0;
            presc     <= '0;
          end else if (load_evt || presc == TICK_LAST) begin
            presc <= '0;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: begin
          state     <= MANUAL;
          auto_mode <= 1'b0;
          presc     <= '0;
        end
      endcase
    end
  end

  assign bus.ld_o   = ld;
  assign bus.cnt_o  = cnt;
  assign bus.d_o    = d;
  assign bus.auto_o = auto_mode;
endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// tb_counter_cmd_ctrl
// Self-checking bench for counter_cmd_ctrl with DEBOUNCE_CYCLES=4 and
// TICK_DIV=5. Edge numbers are counted by the bench; a level first sampled
// on edge t is accepted by the debouncer only after DEBOUNCE_CYCLES
// consecutive samples, and a resulting press strobes on edge
// t + DEBOUNCE_CYCLES + 2.
module tb_counter_cmd_ctrl;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int TD = 5;
  localparam int N  = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  int           ld_q[$];
  int           cnt_q[$];
  logic [W-1:0] dq[$];

  counter_cmd_ctrl_if #(.W(W)) bus ();

  counter_cmd_ctrl #(
    .W(W),
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.ld_o === 1'b1) begin
      ld_q.push_back(cyc);
      dq.push_back(bus.d_o);
    end
    if (bus.cnt_o === 1'b1) cnt_q.push_back(cyc);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 50000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mon();
    ld_q.delete();
    cnt_q.delete();
    dq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit has(input int q[$], input int e);
    foreach (q[i]) if (q[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    bus.btn_load_i = 1'b0;
    bus.btn_step_i = 1'b0;
    bus.sw_auto_i  = 1'b0;
    bus.sw_data_i  = '0;
    rst_n = 1'b0;
    idle(3);
    checks++; if (bus.ld_o !== 1'b0) begin failures++; $display("FAIL reset_ld: got %b expected 0", bus.ld_o); end
    checks++; if (bus.cnt_o !== 1'b0) begin failures++; $display("FAIL reset_cnt: got %b expected 0", bus.cnt_o); end
    checks++; if (bus.d_o !== 4'h0) begin failures++; $display("FAIL reset_d: got %h expected 0", bus.d_o); end
    checks++; if (bus.auto_o !== 1'b0) begin failures++; $display("FAIL reset_auto: got %b expected 0", bus.auto_o); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_load_latency();
    int t;
    clear_mon();
    @(negedge clk);
    bus.sw_data_i  = 4'hA;
    bus.btn_load_i = 1'b1;
    t = cyc + 1;
    idle(20);
    bus.btn_load_i = 1'b0;
    bus.sw_data_i  = 4'h5;
    idle(15);
    checks++; if (ld_q.size() != 1) begin failures++; $display("FAIL load_count: got %0d expected 1", ld_q.size()); end
    checks++; if (ld_q.size() == 0 || ld_q[0] != t + D + 2) begin failures++; $display("FAIL load_latency: got edge %0d expected %0d", (ld_q.size() > 0) ? ld_q[0] - t + 1 : -1, D + 3); end
    checks++; if (dq.size() == 0 || dq[0] !== 4'hA) begin failures++; $display("FAIL load_data: got %h expected a", (dq.size() > 0) ? dq[0] : 4'hx); end
    checks++; if (bus.d_o !== 4'hA) begin failures++; $display("FAIL load_hold: got %h expected a", bus.d_o); end
    checks++; if (cnt_q.size() != 0) begin failures++; $display("FAIL load_no_cnt: got %0d pulses expected 0", cnt_q.size()); end
  endtask

  task automatic test_step_bounce();
    int t;
    clear_mon();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.btn_step_i = ((i / 2) % 2 == 0);
    end
    @(negedge clk);
    bus.btn_step_i = 1'b0;
    idle(10);
    checks++; if (cnt_q.size() != 0) begin failures++; $display("FAIL bounce_cnt: got %0d pulses expected 0", cnt_q.size()); end
    clear_mon();
    @(negedge clk);
    bus.btn_step_i = 1'b1;
    t = cyc + 1;
    idle(10);
    bus.btn_step_i = 1'b0;
    idle(10);
    checks++; if (cnt_q.size() != 1) begin failures++; $display("FAIL step_count: got %0d expected 1", cnt_q.size()); end
    checks++; if (cnt_q.size() == 0 || cnt_q[0] != t + D + 2) begin failures++; $display("FAIL step_latency: got %0d expected %0d", (cnt_q.size() > 0) ? cnt_q[0] : -1, t + D + 2); end
    checks++; if (ld_q.size() != 0) begin failures++; $display("FAIL step_no_ld: got %0d expected 0", ld_q.size()); end
  endtask

  task automatic test_auto();
    int t;
    int n;
    int bad;
    clear_mon();
    @(negedge clk);
    bus.sw_auto_i = 1'b1;
    t = cyc + 1;
    idle(2);
    checks++; if (bus.auto_o !== 1'b0) begin failures++; $display("FAIL auto_early: got %b expected 0", bus.auto_o); end
    idle(1);
    checks++; if (bus.auto_o !== 1'b1) begin failures++; $display("FAIL auto_entry: got %b expected 1", bus.auto_o); end
    idle(37);
    bus.sw_auto_i = 1'b0;
    idle(15);
    checks++; if (bus.auto_o !== 1'b0) begin failures++; $display("FAIL auto_exit: got %b expected 0", bus.auto_o); end
    n = cnt_q.size();
    checks++; if (n < 7 || n > 9) begin failures++; $display("FAIL auto_pulses: got %0d expected 8 +-1", n); end
    checks++; if (n == 0 || cnt_q[0] != t + 2 + TD) begin failures++; $display("FAIL auto_first: got %0d expected %0d", (n > 0) ? cnt_q[0] : -1, t + 2 + TD); end
    bad = 0;
    for (int i = 1; i < n; i++) if (cnt_q[i] - cnt_q[i-1] != TD) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL auto_period: got %0d bad gaps expected 0", bad); end
    checks++; if (n > 0 && cnt_q[n-1] > t + 42) begin failures++; $display("FAIL auto_stop: got last pulse %0d expected <= %0d", cnt_q[n-1], t + 42); end
    checks++; if (ld_q.size() != 0) begin failures++; $display("FAIL auto_no_ld: got %0d expected 0", ld_q.size()); end
  endtask

  task automatic test_load_on_tick();
    int ta;
    int gap;
    clear_mon();
    @(negedge clk);
    bus.sw_auto_i = 1'b1;
    ta = cyc + 1;
    idle(16);
    bus.btn_load_i = 1'b1;
    bus.sw_data_i  = 4'h3;
    idle(8);
    bus.btn_load_i = 1'b0;
    idle(12);
    bus.sw_auto_i = 1'b0;
    idle(12);
    checks++; if (ld_q.size() != 1 || ld_q[0] != ta + 22) begin failures++; $display("FAIL tick_ld: got %0d pulses first %0d expected 1 at %0d", ld_q.size(), (ld_q.size() > 0) ? ld_q[0] : -1, ta + 22); end
    checks++; if (!has(cnt_q, ta + 17)) begin failures++; $display("FAIL tick_before: got no pulse expected pulse at %0d", ta + 17); end
    checks++; if (has(cnt_q, ta + 22)) begin failures++; $display("FAIL tick_priority: got cnt_o=1 expected 0 at %0d", ta + 22); end
    gap = 0;
    for (int e = ta + 23; e < ta + 27; e++) if (has(cnt_q, e)) gap++;
    checks++; if (gap != 0) begin failures++; $display("FAIL tick_gap: got %0d early pulses expected 0", gap); end
    checks++; if (!has(cnt_q, ta + 27)) begin failures++; $display("FAIL tick_after: got no pulse expected pulse at %0d", ta + 27); end
    checks++; if (dq.size() == 0 || dq[0] !== 4'h3) begin failures++; $display("FAIL tick_data: got %h expected 3", (dq.size() > 0) ? dq[0] : 4'hx); end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_mon();
    @(negedge clk);
    bus.btn_load_i = 1'b1;
    bus.sw_data_i  = 4'h6;
    idle(3);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ld_o !== 1'b0) begin failures++; $display("FAIL rstmid_ld: got %b expected 0", bus.ld_o); end
    checks++; if (bus.cnt_o !== 1'b0) begin failures++; $display("FAIL rstmid_cnt: got %b expected 0", bus.cnt_o); end
    checks++; if (bus.d_o !== 4'h0) begin failures++; $display("FAIL rstmid_d: got %h expected 0", bus.d_o); end
    checks++; if (bus.auto_o !== 1'b0) begin failures++; $display("FAIL rstmid_auto: got %b expected 0", bus.auto_o); end
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc + 1;
    idle(15);
    bus.btn_load_i = 1'b0;
    idle(10);
    checks++; if (ld_q.size() != 1 || ld_q[0] != t + D + 2) begin failures++; $display("FAIL rstmid_reload: got %0d pulses first %0d expected 1 at %0d", ld_q.size(), (ld_q.size() > 0) ? ld_q[0] : -1, t + D + 2); end
    checks++; if (dq.size() == 0 || dq[0] !== 4'h6) begin failures++; $display("FAIL rstmid_data: got %h expected 6", (dq.size() > 0) ? dq[0] : 4'hx); end
    checks++; if (cnt_q.size() != 0) begin failures++; $display("FAIL rstmid_no_cnt: got %0d expected 0", cnt_q.size()); end
  endtask

  // Random press/bounce traffic on both buttons in manual mode. Expected
  // presses come from run lengths of the raw sequence: an opposite-level
  // run of at least D samples is accepted, and a rising one strobes D+2
  // edges after its first sample.
  task automatic test_random();
    bit           raw [2][N];
    logic [W-1:0] dat [N];
    int           exp_ld[$];
    int           exp_st[$];
    int           exp_cnt[$];
    int           t0;
    for (int b = 0; b < 2; b++) begin
      int i;
      bit lv;
      i  = 0;
      lv = 1'b1;
      while (i < N) begin
        int len;
        if (b == 1 && lv == 1'b0) len = $urandom_range(8, D);
        else len = $urandom_range(8, 1);
        for (int k = 0; k < len && i < N; k++) begin
          raw[b][i] = lv;
          i++;
        end
        lv = ~lv;
      end
      for (int k = N - 12; k < N; k++) raw[b][k] = 1'b0;
    end
    dat[0] = 4'($urandom_range(15, 0));
    for (int i = 1; i < N; i++)
      dat[i] = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 0)) : dat[i-1];
    for (int b = 0; b < 2; b++) begin
      int i;
      bit acc;
      i   = 0;
      acc = 1'b0;
      while (i < N) begin
        int j;
        j = i;
        while (j < N && raw[b][j] == raw[b][i]) j++;
        if (raw[b][i] != acc && j - i >= D) begin
          acc = raw[b][i];
          if (acc) begin
            if (b == 0) exp_ld.push_back(i + D + 2);
            else exp_st.push_back(i + D + 2);
          end
        end
        i = j;
      end
    end
    foreach (exp_st[k]) if (!has(exp_ld, exp_st[k])) exp_cnt.push_back(exp_st[k]);
    clear_mon();
    t0 = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc + 1;
      bus.btn_load_i = raw[0][i];
      bus.btn_step_i = raw[1][i];
      bus.sw_data_i  = dat[i];
    end
    idle(20);
    checks++;
    if (ld_q.size() != exp_ld.size()) begin
      failures++; $display("FAIL rand_ld_count: got %0d expected %0d", ld_q.size(), exp_ld.size());
    end else begin
      foreach (exp_ld[k]) begin
        checks++; if (ld_q[k] != t0 + exp_ld[k]) begin failures++; $display("FAIL rand_ld_edge: got %0d expected %0d", ld_q[k], t0 + exp_ld[k]); end
        checks++; if (dq[k] !== dat[exp_ld[k] - 2]) begin failures++; $display("FAIL rand_ld_data: got %h expected %h", dq[k], dat[exp_ld[k] - 2]); end
      end
    end
    checks++;
    if (cnt_q.size() != exp_cnt.size()) begin
      failures++; $display("FAIL rand_cnt_count: got %0d expected %0d", cnt_q.size(), exp_cnt.size());
    end else begin
      foreach (exp_cnt[k]) begin
        checks++; if (cnt_q[k] != t0 + exp_cnt[k]) begin failures++; $display("FAIL rand_cnt_edge: got %0d expected %0d", cnt_q[k], t0 + exp_cnt[k]); end
      end
    end
  endtask

  task automatic test_repeat();
    int t;
    int exp[$];
    clear_mon();
    @(negedge clk);
    bus.btn_step_i = 1'b1;
    t = cyc + 1;
    idle(80);
    bus.btn_step_i = 1'b0;
    idle(15);
    exp.push_back(t + D + 2);
`ifdef CNT_CTRL_STEP_REPEAT_EN
    // repeats start 8*TD after the press and run while the debounced
    // level is still high (it falls D+1 edges after the first low sample)
    for (int e = t + D + 2 + 8 * TD; e <= t + 80 + D + 1; e += TD) exp.push_back(e);
`endif
    checks++;
    if (cnt_q.size() != exp.size()) begin
      failures++; $display("FAIL repeat_count: got %0d expected %0d", cnt_q.size(), exp.size());
    end else begin
      foreach (exp[k]) begin
        checks++; if (cnt_q[k] != exp[k]) begin failures++; $display("FAIL repeat_edge: got %0d expected %0d", cnt_q[k], exp[k]); end
      end
    end
    checks++; if (ld_q.size() != 0) begin failures++; $display("FAIL repeat_no_ld: got %0d expected 0", ld_q.size()); end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_step_bounce();
    test_auto();
    test_load_on_tick();
    test_reset_mid();
    test_random();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_cmd_ctrl.md
Name: counter_cmd_ctrl

Overview:
Command front-end for the 4-bit loadable up-counter. Synchronises and debounces the board push-buttons and switches, and converts presses into single-cycle load and count-enable strobes. Also generates an auto-count tick in auto mode. Outputs connect directly to the counter's load, count and data inputs.

Parameters:
W, 4, width of load data path (d_o, sw_data_i)
DEBOUNCE_CYCLES, 20000, consecutive stable synchronised cycles needed to accept a button level change (min 2)
TICK_DIV, 50000000, clk cycles per auto-count tick (min 2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
btn_load_i  input  1  raw async load button, active-high
btn_step_i  input  1  raw async step button, active-high
sw_auto_i  input  1  raw async mode switch; 1 = auto count, 0 = manual step
sw_data_i  input  W  raw async load value switches
ld_o  output  1  one-cycle load strobe to counter
cnt_o  output  1  one-cycle count strobe to counter
d_o  output  W  load value; valid while ld_o=1, held until next load
auto_o  output  1  current mode; 1 = AUTO state

Behaviour:
- Reset (async, rst_n=0): ld_o=0, cnt_o=0, d_o=0, auto_o=0, all synchronisers/debounce/prescaler = 0, FSM = MANUAL.
- Inputs btn_load_i, btn_step_i, sw_auto_i and sw_data_i each pass through 2-flop synchronisers.
- Debounce, per button:
  - Counter increments every cycle that the synchronised level differs from the debounced level; clears on any cycle they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level flips and the counter clears.
- Edge detect: a debounced 0->1 transition produces a press event. Releases produce nothing.
- Load latency: with btn_load_i held high, ld_o asserts on exactly the (DEBOUNCE_CYCLES+3)th rising edge after the first edge sampling it high, for exactly 1 cycle.
- Load data: d_o is registered from synchronised sw_data_i on the same edge that ld_o rises, and holds until the next load.
- FSM states: MANUAL, AUTO.
  - MANUAL->AUTO when synchronised sw_auto_i=1.
  - AUTO->MANUAL when synchronised sw_auto_i=0.
  - auto_o = (state==AUTO).
- MANUAL mode: a step press event gives a one-cycle cnt_o pulse with the same latency as load. The prescaler is held at 0.
- AUTO mode: the prescaler counts 0..TICK_DIV-1 and wraps. cnt_o pulses for 1 cycle on the cycle after the prescaler equals TICK_DIV-1. Step presses are ignored.
- Prescaler clears to 0 on entry to AUTO and on every load event, so the first tick after entry/load comes TICK_DIV cycles later.
- Priority: ld_o and cnt_o are never high in the same cycle. If a load event and a count event coincide, ld_o asserts and the count event is dropped (not deferred).
- A step press pending when the mode switches to AUTO is discarded.
- rst_n asserted mid-debounce or mid-pulse clears everything immediately. A button still held after reset release must be re-debounced and still produces exactly one press event.
- A button held indefinitely produces exactly one press. Bounces shorter than DEBOUNCE_CYCLES produce none.

Optional Feature:
- Macro: CNT_CTRL_STEP_REPEAT_EN.
- When defined, in MANUAL mode: if the debounced step button stays high for 8*TICK_DIV cycles after its press event, cnt_o pulses every TICK_DIV cycles until release or a mode change. Load priority still applies.
- When undefined: a held step button produces exactly one cnt_o pulse, and no repeat logic is synthesised.

Test Plan:
- DEBOUNCE_CYCLES=4, TICK_DIV=5, reset, sw_data_i=4'hA, btn_load_i high 20 cycles -> one ld_o pulse exactly 7 edges after first sample; d_o=4'hA held afterwards; cnt_o stays 0.
- btn_step_i toggling every 2 cycles for 30 cycles, then steady low -> cnt_o never asserts; steady high 10 cycles -> exactly one cnt_o pulse.
- sw_auto_i=1 for 40 cycles -> auto_o=1 after 3 edges; cnt_o pulses every 5 cycles, with the first pulse 5 cycles after entry; 8 pulses total (±1 at exit); sw_auto_i=0 -> pulses stop, auto_o=0.
- AUTO mode, load press timed to debounce exactly on a tick cycle -> ld_o=1 and cnt_o=0 that cycle; next cnt_o 5 cycles later.
- rst_n low for 1 cycle mid-debounce of a held load button -> all outputs 0; after release, one ld_o pulse 7 edges later.
- CNT_CTRL_STEP_REPEAT_EN defined, step held 80 cycles in MANUAL -> first pulse at press, repeats begin 40 cycles later, then every 5 cycles until release; undefined -> single pulse.
